// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider: one quotient bit per clock, signed or unsigned,
// with quotient/remainder, divide-by-zero and overflow flags and a start/busy/finished handshake.
module seq_divider #(
   parameter int unsigned N = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         signed_mode,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         finished,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  rem_q, rem_d;     // partial remainder
   logic [N-1:0]  dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
   logic [N-1:0]  dsr_q, dsr_d;     // divisor magnitude
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_quo_q, neg_quo_d;
   logic          neg_rem_q, neg_rem_d;
   logic          ovf_pend_q, ovf_pend_d;
   logic [N-1:0]  quo_out_q, quo_out_d;
   logic [N-1:0]  rem_out_q, rem_out_d;
   logic          dbz_q, dbz_d;
   logic          ovf_q, ovf_d;

   logic [N:0]    shift_w;
   logic [N:0]    diff_w;
   logic          ge_w;

   function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic sm);
      return (sm && x[N-1]) ? (~x + One) : x;
   endfunction

   assign shift_w = {rem_q, dvd_q[N-1]};
   assign diff_w  = shift_w - {1'b0, dsr_q};
   // Remainder stays below the divisor, so bit N of the difference is a pure borrow.
   assign ge_w    = ~diff_w[N];

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      dvd_d      = dvd_q;
      dsr_d      = dsr_q;
      cnt_d      = cnt_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      ovf_pend_d = ovf_pend_q;
      quo_out_d  = quo_out_q;
      rem_out_d  = rem_out_q;
      dbz_d      = dbz_q;
      ovf_d      = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               dbz_d      = 1'b0;
               ovf_d      = 1'b0;
               neg_quo_d  = signed_mode & (dividend[N-1] ^ divisor[N-1]);
               neg_rem_d  = signed_mode & dividend[N-1];
               ovf_pend_d = signed_mode && (dividend == MinNeg) && (divisor == '1);
               if (divisor == '0) begin
                  quo_out_d = '1;
                  rem_out_d = dividend;
                  dbz_d     = 1'b1;
                  state_d   = StDone;
               end else begin
                  dvd_d   = mag(dividend, signed_mode);
                  dsr_d   = mag(divisor, signed_mode);
                  rem_d   = '0;
                  cnt_d   = CW'(N - 1);
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            rem_d = ge_w ? diff_w[N-1:0] : shift_w[N-1:0];
            dvd_d = {dvd_q[N-2:0], ge_w};
            if (cnt_q == '0) begin
               state_d = StFix;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StFix: begin
            quo_out_d = neg_quo_q ? (~dvd_q + One) : dvd_q;
            rem_out_d = neg_rem_q ? (~rem_q + One) : rem_q;
            ovf_d     = ovf_pend_q;
            state_d   = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         rem_q      <= '0;
         dvd_q      <= '0;
         dsr_q      <= '0;
         cnt_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         ovf_pend_q <= 1'b0;
         quo_out_q  <= '0;
         rem_out_q  <= '0;
         dbz_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         dsr_q      <= dsr_d;
         cnt_q      <= cnt_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         ovf_pend_q <= ovf_pend_d;
         quo_out_q  <= quo_out_d;
         rem_out_q  <= rem_out_d;
         dbz_q      <= dbz_d;
         ovf_q      <= ovf_d;
      end
   end

   assign quotient    = quo_out_q;
   assign remainder   = rem_out_q;
   assign busy        = (state_q == StCalc) || (state_q == StFix);
   assign finished    = (state_q == StDone);
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: 8-bit and 16-bit instances, hand-computed expected results.
module tb_seq_divider;

   logic        clock = 1'b0;
   logic        reset = 1'b0;

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  dvd8 = '0, dsr8 = '0, q8, r8;
   logic        busy8, fin8, dbz8, ovf8;

   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] dvd16 = '0, dsr16 = '0, q16, r16;
   logic        busy16, fin16, dbz16, ovf16;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   seq_divider #(.N(8)) u_dut8 (
      .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8),
      .dividend(dvd8), .divisor(dsr8), .quotient(q8), .remainder(r8),
      .busy(busy8), .finished(fin8), .div_by_zero(dbz8), .overflow(ovf8)
   );

   seq_divider #(.N(16)) u_dut16 (
      .clock(clock), .reset(reset), .start(start16), .signed_mode(sm16),
      .dividend(dvd16), .divisor(dsr16), .quotient(q16), .remainder(r16),
      .busy(busy16), .finished(fin16), .div_by_zero(dbz16), .overflow(ovf16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issues one operation and checks latency, busy cycles, results, flags and the finished fall.
   task automatic div_case(input string tag, input bit wide, input logic sm,
                           input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic edbz, input logic eovf);
      int lat;
      int bcyc;
      tick();
      if (wide) begin
         start16 = 1'b1; sm16 = sm; dvd16 = a; dsr16 = b;
      end else begin
         start8 = 1'b1; sm8 = sm; dvd8 = a[7:0]; dsr8 = b[7:0];
      end
      tick();
      start8 = 1'b0;
      start16 = 1'b0;
      lat = 1;
      bcyc = wide ? int'(busy16) : int'(busy8);
      while (!(wide ? fin16 : fin8) && lat < 60) begin
         tick();
         lat++;
         bcyc += wide ? int'(busy16) : int'(busy8);
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy"}, 32'(bcyc), edbz ? 32'd0 : 32'(exp_lat - 1));
      check({tag, "_quo"}, wide ? {16'h0, q16} : {24'h0, q8}, {16'h0, eq});
      check({tag, "_rem"}, wide ? {16'h0, r16} : {24'h0, r8}, {16'h0, er});
      check({tag, "_flags"}, wide ? {30'h0, dbz16, ovf16} : {30'h0, dbz8, ovf8},
            {30'h0, edbz, eovf});
      tick();
      check({tag, "_finfall"}, wide ? {31'h0, fin16} : {31'h0, fin8}, 32'h0);
   endtask

   initial begin
      int nfin;
      int first;
      #2;
      check("reset_outs8", {12'h0, q8, r8, busy8, fin8, dbz8, ovf8}, 32'h0);
      check("reset_outs16", {q16, r16}, 32'h0);
      repeat (2) tick();
      reset = 1'b1;

      div_case("u200_7", 1'b0, 1'b0, 16'd200, 16'd7, 10, 16'd28, 16'd4, 1'b0, 1'b0);
      div_case("sm7_2", 1'b0, 1'b1, 16'h00F9, 16'h0002, 10, 16'h00FD, 16'h00FF, 1'b0, 1'b0);
      div_case("s7_m2", 1'b0, 1'b1, 16'h0007, 16'h00FE, 10, 16'h00FD, 16'h0001, 1'b0, 1'b0);
      div_case("s_ovf", 1'b0, 1'b1, 16'h0080, 16'h00FF, 10, 16'h0080, 16'h0000, 1'b0, 1'b1);
      div_case("u_noovf", 1'b0, 1'b0, 16'h0080, 16'h00FF, 10, 16'h0000, 16'h0080, 1'b0, 1'b0);
      div_case("dbz13", 1'b0, 1'b0, 16'd13, 16'd0, 1, 16'h00FF, 16'd13, 1'b1, 1'b0);
      check("dbz_hold", {23'h0, q8, dbz8}, {23'h0, 8'hFF, 1'b1});
      div_case("u9_3", 1'b0, 1'b0, 16'd9, 16'd3, 10, 16'd3, 16'd0, 1'b0, 1'b0);

      // Second start while busy must be ignored.
      tick();
      start8 = 1'b1; sm8 = 1'b0; dvd8 = 8'd100; dsr8 = 8'd9;
      nfin = 0;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 1) start8 = 1'b0;
         if (i == 3) begin
            start8 = 1'b1; dvd8 = 8'd50; dsr8 = 8'd5;
         end
         if (i == 4) start8 = 1'b0;
         if (fin8) begin
            nfin++;
            if (first == 0) first = i;
         end
      end
      check("repulse_nfin", 32'(nfin), 32'd1);
      check("repulse_lat", 32'(first), 32'd10);
      check("repulse_res", {16'h0, q8, r8}, {16'h0, 8'd11, 8'd1});

      // Asynchronous reset mid-operation.
      tick();
      start8 = 1'b1; dvd8 = 8'd100; dsr8 = 8'd9;
      tick();
      start8 = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check("abort_outs", {12'h0, q8, r8, busy8, fin8, dbz8, ovf8}, 32'h0);
      nfin = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) reset = 1'b1;
         tick();
         nfin += int'(fin8);
      end
      check("abort_nofin", 32'(nfin), 32'd0);
      div_case("fresh9_3", 1'b0, 1'b0, 16'd9, 16'd3, 10, 16'd3, 16'd0, 1'b0, 1'b0);

      div_case("w_u65535", 1'b1, 1'b0, 16'hFFFF, 16'd255, 18, 16'd257, 16'd0, 1'b0, 1'b0);
      div_case("w_sneg", 1'b1, 1'b1, 16'h8000, 16'd3, 18, 16'hD556, 16'hFFFE, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
